// File: rtl/cla32_pipe.sv
// Two-stage pipelined 32-bit add/subtract unit built from 4-bit carry-lookahead cells.
// Stage 1 registers bit and group generate/propagate terms; stage 2 resolves carries, sum and flags.
module cla32_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  // Carries out of each bit position of a 4-bit lookahead cell: [0] into bit 1 ... [3] out of bit 3.
  function automatic logic [3:0] cla4_carry(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Group {G, P} of a 4-bit cell.
  function automatic logic [1:0] cla4_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  // Handshake: a transfer happens when valid & ready are both high at a rising edge.
  // The output stage advances when empty or drained; stage 1 advances when empty or
  // when the output stage advances; in_ready is combinational from out_ready.
  logic out_adv, s1_adv, s1_valid;
  assign out_adv  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || out_adv;
  assign in_ready = s1_adv;

  logic [WIDTH-1:0] b_eff, g_in, p_in;
  logic [7:0]       gg_in, gp_in;
  assign b_eff = b ^ {WIDTH{sub}};
  assign g_in  = a & b_eff;
  assign p_in  = a | b_eff;

  always_comb begin
    gg_in = '0;
    gp_in = '0;
    for (int k = 0; k < 8; k++) begin
      {gg_in[k], gp_in[k]} = cla4_gp(g_in[4*k +: 4], p_in[4*k +: 4]);
    end
  end

  logic [WIDTH-1:0] a_r, be_r, g_r, p_r;
  logic [7:0]       gg_r, gp_r;
  logic             cin_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      a_r      <= '0;
      be_r     <= '0;
      g_r      <= '0;
      p_r      <= '0;
      gg_r     <= '0;
      gp_r     <= '0;
      cin_r    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        a_r   <= a;
        be_r  <= b_eff;
        g_r   <= g_in;
        p_r   <= p_in;
        gg_r  <= gg_in;
        gp_r  <= gp_in;
        cin_r <= sub;
      end
    end
  end

  // Second lookahead level: lower cell covers groups 0-3, upper cell groups 4-7.
  logic [3:0] lo_c, hi_c;
  logic [7:0] grp_c;
  assign lo_c  = cla4_carry(gg_r[3:0], gp_r[3:0], cin_r);
  assign hi_c  = cla4_carry(gg_r[7:4], gp_r[7:4], lo_c[3]);
  assign grp_c = {hi_c[2:0], lo_c, cin_r};

  logic [WIDTH-1:0] c;
  logic [7:0]       bit_co_unused;
  always_comb begin : bit_carries
    logic [3:0] bc;
    c             = '0;
    bit_co_unused = '0;
    bc            = '0;
    for (int k = 0; k < 8; k++) begin
      bc               = cla4_carry(g_r[4*k +: 4], p_r[4*k +: 4], grp_c[k]);
      c[4*k]           = grp_c[k];
      c[4*k+1 +: 3]    = bc[2:0];
      bit_co_unused[k] = bc[3];
    end
  end

  logic [WIDTH-1:0] sum_d;
  assign sum_d = a_r ^ be_r ^ c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_d;
        cout <= hi_c[3];
        ovf  <= c[WIDTH-1] ^ hi_c[3];
        zero <= (sum_d == '0);
        neg  <= sum_d[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_cla32_pipe.sv
// Directed and randomized bench for cla32_pipe: arithmetic reference model, occupancy model
// for in_ready/out_valid, and an in-order scoreboard of {sum, cout, ovf, zero, neg}.
module tb_cla32_pipe;
  localparam int W = 36;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout, ovf, zero, neg;

  cla32_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           acc_last = 0;
  bit           stall_prev = 0;
  bit           saw_full = 0;
  logic [W-1:0] held = '0;

  // Reference: plain unsigned/signed arithmetic on wide integers.
  function automatic logic [W-1:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] r;
    logic        co, ov;
    longint      sr;
    if (s) begin
      r  = x - y;
      co = (x >= y);
      sr = longint'($signed(x)) - longint'($signed(y));
    end else begin
      r  = x + y;
      co = (longint'(x) + longint'(y)) > 64'hFFFF_FFFF;
      sr = longint'($signed(x)) + longint'($signed(y));
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {r, co, ov, r == 32'd0, r[31]};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: inputs are already driven; sample at the falling edge, return at posedge+1.
  task automatic cycle(output bit acc);
    logic [W-1:0] o;
    bit           drn;
    @(negedge clk);
    o = {sum, cout, ovf, zero, neg};
    check("in_ready", W'(in_ready), W'(!(exp_q.size() == 2 && !out_ready)));
    check("out_valid", W'(out_valid), W'(exp_q.size() == 2 || (exp_q.size() == 1 && !acc_last)));
    if (stall_prev) check("stall_hold", o, held);
    if (!in_ready) saw_full = 1;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      if (exp_q.size() == 0) check("spurious_out", W'(out_valid), W'(0));
      else check("result", o, exp_q.pop_front());
    end
    if (acc) exp_q.push_back(model(a, b, sub));
    acc_last   = acc;
    stall_prev = out_valid && !out_ready;
    held       = o;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(acc);
    check("drain", W'(exp_q.size()), W'(0));
  endtask

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [31:0] esum, input logic [3:0] eflags);
    bit acc;
    drain();
    a = x; b = y; sub = s; in_valid = 1;
    cycle(acc);
    check({tag, "_accept"}, W'(acc), W'(1));
    in_valid = 0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    cycle(acc);
    check({tag, "_latency"}, W'(out_valid), W'(1));
    check(tag, {sum, cout, ovf, zero, neg}, {esum, eflags});
  endtask

  initial begin
    bit acc;
    int sent;
    logic [31:0] corner[6];
    corner = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_FFFF};

    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", W'({out_valid, in_ready}), W'(2'b01));
    check("reset_data", {sum, cout, ovf, zero, neg}, W'(0));
    rst_n = 1;

    // Flags: cout, ovf, zero, neg
    directed("add_carry_zero", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010);
    directed("add_ovf",        32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101);
    directed("sub_ovf",        32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100);
    directed("sub_borrow",     32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 4'b0001);
    directed("sub_noborrow",   32'd7,         32'd5,         1'b1, 32'h0000_0002, 4'b1000);
    directed("sub_equal",      32'h1234,      32'h1234,      1'b1, 32'h0000_0000, 4'b1010);
    drain();

    // Back-pressure: six back-to-back ops, downstream stalled in cycles 3-5.
    sent = 0;
    saw_full = 0;
    for (int k = 0; k < 40 && (sent < 6 || exp_q.size() != 0); k++) begin
      out_ready = !(k >= 3 && k <= 5);
      in_valid  = (sent < 6);
      a = sent; b = 1; sub = 0;
      cycle(acc);
      if (acc) sent++;
    end
    check("bp_sent", W'(sent), W'(6));
    check("bp_drained", W'(exp_q.size()), W'(0));
    check("bp_in_ready_fell", W'(saw_full), W'(1));

    // Reset mid-cycle with both stages full.
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      cycle(acc);
    end
    in_valid = 0;
    #3;
    rst_n = 0;
    #1;
    check("rst_mid_flags", W'({out_valid, in_ready}), W'(2'b01));
    check("rst_mid_data", {sum, cout, ovf, zero, neg}, W'(0));
    exp_q.delete();
    acc_last = 0; stall_prev = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    for (int k = 0; k < 4; k++) cycle(acc);

    // Random traffic.
    sent = 0;
    for (int k = 0; k < 60000 && sent < 10000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      sub = 1'($urandom_range(0, 1));
      cycle(acc);
      if (acc) sent++;
    end
    check("rand_sent", W'(sent), W'(10000));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
